// File: rtl/inst_fetch_seq_if.sv
// Fetch/issue bus for inst_fetch_seq.
// Groups the program-memory read port, the execute issue handshake,
// the execute flags and the sequencer status.
//   master : the sequencer (drives imem_rd_en/imem_addr/ir/ir_valid/pc/halted)
//   slave  : memory + execute side (drives start/imem_rdata/ex_ready/ex_done/flags)
// Signals:
//   start       one-cycle pulse, begins fetch at PC=0 from IDLE
//   imem_rd_en  program memory read strobe
//   imem_addr   program memory address (= pc)
//   imem_rdata  read data, valid one cycle after imem_rd_en
//   ir/ir_valid issued instruction and its valid flag
//   ex_ready    execute accepts ir when ir_valid & ex_ready
//   ex_done     pulse: accepted instruction completed, flags updated
//   zero_f/sign_f/carry_f/ovf_f  execute flags
//   pc          current program counter
//   halted      HALT has been executed
interface inst_fetch_seq_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned IR_W   = 32
);
  logic              start;
  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [IR_W-1:0]   imem_rdata;
  logic [IR_W-1:0]   ir;
  logic              ir_valid;
  logic              ex_ready;
  logic              ex_done;
  logic              zero_f;
  logic              sign_f;
  logic              carry_f;
  logic              ovf_f;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  modport master (
    input  start, imem_rdata, ex_ready, ex_done, zero_f, sign_f, carry_f, ovf_f,
    output imem_rd_en, imem_addr, ir, ir_valid, pc, halted
  );

  modport slave (
    output start, imem_rdata, ex_ready, ex_done, zero_f, sign_f, carry_f, ovf_f,
    input  imem_rd_en, imem_addr, ir, ir_valid, pc, halted
  );
endinterface

// File: rtl/inst_fetch_seq.sv
// Instruction fetch/sequencer.
// Fetches instructions from program memory at PC, issues datapath ops to
// the execute unit through a valid/ready handshake and resolves jumps,
// conditional jumps and HALT locally from the execute flags.
// Ports:
//   clk      system clock, rising edge
//   sys_rst  synchronous active-high reset
//   bus      inst_fetch_seq_if.master (memory, issue, flags, status)
// Instruction fields: oper_type=[31:27], isrc=[15:0]; jump target is
// isrc[ADDR_W-1:0].
module inst_fetch_seq #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned IR_W   = 32
) (
  input logic           clk,
  input logic           sys_rst,
  inst_fetch_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT_EX,
    S_RESOLVE,
    S_NEXT,
    S_HALT
  } state_t;

  localparam logic [4:0] OP_JMP   = 5'd16;
  localparam logic [4:0] OP_JC    = 5'd17;
  localparam logic [4:0] OP_JNC   = 5'd18;
  localparam logic [4:0] OP_JS    = 5'd19;
  localparam logic [4:0] OP_JNS   = 5'd20;
  localparam logic [4:0] OP_JZ    = 5'd21;
  localparam logic [4:0] OP_JNZ   = 5'd22;
  localparam logic [4:0] OP_JO    = 5'd23;
  localparam logic [4:0] OP_JNO   = 5'd24;
  localparam logic [4:0] OP_HALT  = 5'd25;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [IR_W-1:0]   ir_q;
  logic              ir_valid_q;
  logic              rd_en_q;
  logic              halted_q;

  logic [4:0]        load_op;
  logic              load_is_ctrl;
  logic [4:0]        ir_op;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jmp_target;
  logic              jmp_taken;

  assign load_op      = bus.imem_rdata[31:27];
  assign load_is_ctrl = (load_op >= OP_JMP) && (load_op <= OP_HALT);
  assign ir_op        = ir_q[31:27];
  // Natural ADDR_W-bit wrap gives modulo-2^ADDR_W PC arithmetic.
  assign pc_inc       = pc_q + ADDR_W'(1);
  assign jmp_target   = ir_q[ADDR_W-1:0];

  always_comb begin
    jmp_taken = 1'b0;
    case (ir_op)
      OP_JMP:  jmp_taken = 1'b1;
      OP_JC:   jmp_taken = bus.carry_f;
      OP_JNC:  jmp_taken = !bus.carry_f;
      OP_JS:   jmp_taken = bus.sign_f;
      OP_JNS:  jmp_taken = !bus.sign_f;
      OP_JZ:   jmp_taken = bus.zero_f;
      OP_JNZ:  jmp_taken = !bus.zero_f;
      OP_JO:   jmp_taken = bus.ovf_f;
      OP_JNO:  jmp_taken = !bus.ovf_f;
      default: jmp_taken = 1'b0;
    endcase
  end

  // Read strobe is registered: it is high for exactly the FETCH cycle, so it
  // is set on every transition into FETCH and cleared by default otherwise.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            pc_q    <= '0;
            rd_en_q <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          ir_q <= bus.imem_rdata;
          if (load_is_ctrl) begin
            state_q <= S_RESOLVE;
          end else begin
            ir_valid_q <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.ex_ready) begin
            ir_valid_q <= 1'b0;
            state_q    <= S_WAIT_EX;
          end
        end
        S_WAIT_EX: begin
          if (bus.ex_done) begin
            pc_q    <= pc_inc;
            state_q <= S_NEXT;
          end
        end
        S_RESOLVE: begin
          if (ir_op == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            pc_q    <= jmp_taken ? jmp_target : pc_inc;
            rd_en_q <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_NEXT: begin
          rd_en_q <= 1'b1;
          state_q <= S_FETCH;
        end
        S_HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_rd_en = rd_en_q;
  assign bus.imem_addr  = pc_q;
  assign bus.ir         = ir_q;
  assign bus.ir_valid   = ir_valid_q;
  assign bus.pc         = pc_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Directed bench for inst_fetch_seq: synchronous program memory model,
// execute handshake driven from a single stimulus sequence.
module tb_inst_fetch_seq;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned IR_W   = 32;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;

  inst_fetch_seq_if #(.ADDR_W(ADDR_W), .IR_W(IR_W)) bus ();

  inst_fetch_seq #(.ADDR_W(ADDR_W), .IR_W(IR_W)) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  int          checks = 0;
  int          errors = 0;
  int          fetch_cnt = 0;
  int          acc_cnt = 0;
  logic [3:0]  last_fetch = '0;
  logic [31:0] acc_log [8];

  // Program memory: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_rdata <= mem[bus.imem_addr];
  end

  // Observe fetches and issue handshakes.
  always @(posedge clk) begin
    if (bus.imem_rd_en) begin
      fetch_cnt  <= fetch_cnt + 1;
      last_fetch <= bus.imem_addr;
    end
    if (bus.ir_valid && bus.ex_ready) begin
      acc_log[acc_cnt % 8] <= bus.ir;
      acc_cnt <= acc_cnt + 1;
    end
  end

  function automatic logic [31:0] enc(input int unsigned op, input int unsigned rdst,
                                      input int unsigned rs1, input int unsigned imm,
                                      input int unsigned src);
    logic [31:0] w;
    w = '0;
    w[31:27] = op[4:0];
    w[26:22] = rdst[4:0];
    w[21:17] = rs1[4:0];
    w[16]    = imm[0];
    w[15:0]  = src[15:0];
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick(2);
    sys_rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.ir_valid) break;
      tick(1);
    end
    check(tag, 32'(bus.ir_valid), 32'd1);
  endtask

  task automatic wait_halted(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.halted) break;
      tick(1);
    end
    check(tag, 32'(bus.halted), 32'd1);
  endtask

  task automatic clear_mem();
    for (int unsigned i = 0; i < 16; i++) mem[i] = '0;
  endtask

  initial begin
    logic [31:0] adi, movi, hlt, andop;
    int f0, a0;

    adi   = enc(2, 0, 2, 1, 4);
    movi  = enc(1, 4, 0, 1, 55);
    hlt   = enc(25, 0, 0, 0, 0);
    andop = enc(6, 1, 2, 0, 3 << 11);

    bus.start = 1'b0; bus.ex_ready = 1'b0; bus.ex_done = 1'b0;
    bus.zero_f = 1'b0; bus.sign_f = 1'b0; bus.carry_f = 1'b0; bus.ovf_f = 1'b0;
    bus.imem_rdata = '0;
    clear_mem();

    // Reset / idle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      check("idle_pc", 32'(bus.pc), 32'd0);
      check("idle_valid", 32'(bus.ir_valid), 32'd0);
      check("idle_halted", 32'(bus.halted), 32'd0);
      check("idle_rden", 32'(bus.imem_rd_en), 32'd0);
      tick(1);
    end

    // Linear issue: ADI, MOVI, HALT
    clear_mem();
    mem[0] = adi; mem[1] = movi; mem[2] = hlt;
    bus.ex_ready = 1'b1;
    f0 = fetch_cnt; a0 = acc_cnt;
    pulse_start();
    check("lin_first_fetch", 32'(bus.imem_rd_en), 32'd1);
    tick(2);
    check("lin_latency3", 32'(bus.ir_valid), 32'd1);
    wait_valid("lin_v0");
    check("lin_ir0", bus.ir, adi);
    check("lin_pc0", 32'(bus.pc), 32'd0);
    tick(1);
    check("lin_wait_pc", 32'(bus.pc), 32'd0);
    bus.ex_done = 1'b1; tick(1); bus.ex_done = 1'b0;
    check("lin_pc1", 32'(bus.pc), 32'd1);
    wait_valid("lin_v1");
    check("lin_ir1", bus.ir, movi);
    tick(1);
    bus.ex_done = 1'b1; tick(1); bus.ex_done = 1'b0;
    wait_halted("lin_halt");
    check("lin_halt_pc", 32'(bus.pc), 32'd2);
    check("lin_halt_valid", 32'(bus.ir_valid), 32'd0);
    tick(10);
    check("lin_fetches", 32'(fetch_cnt - f0), 32'd3);
    check("lin_accepts", 32'(acc_cnt - a0), 32'd2);
    check("lin_acc0", acc_log[a0 % 8], adi);
    check("lin_acc1", acc_log[(a0 + 1) % 8], movi);
    check("lin_rden_after", 32'(bus.imem_rd_en), 32'd0);
    check("lin_still_halted", 32'(bus.halted), 32'd1);

    // Backpressure
    do_reset();
    clear_mem();
    mem[0] = adi; mem[1] = hlt;
    bus.ex_ready = 1'b0;
    a0 = acc_cnt;
    pulse_start();
    wait_valid("bp_v");
    for (int i = 0; i < 7; i++) begin
      check("bp_hold_valid", 32'(bus.ir_valid), 32'd1);
      check("bp_hold_ir", bus.ir, adi);
      check("bp_hold_pc", 32'(bus.pc), 32'd0);
      tick(1);
    end
    bus.ex_ready = 1'b1;
    check("bp_last_valid", 32'(bus.ir_valid), 32'd1);
    check("bp_last_ir", bus.ir, adi);
    tick(1);
    bus.ex_ready = 1'b0;
    check("bp_drop_valid", 32'(bus.ir_valid), 32'd0);
    check("bp_one_accept", 32'(acc_cnt - a0), 32'd1);
    tick(3);
    check("bp_pc_wait", 32'(bus.pc), 32'd0);
    check("bp_ex_done_stall_ir", bus.ir, adi);
    bus.ex_done = 1'b1; tick(1); bus.ex_done = 1'b0;
    check("bp_pc_done", 32'(bus.pc), 32'd1);
    wait_halted("bp_halt");
    check("bp_accepts", 32'(acc_cnt - a0), 32'd1);

    // Conditional jumps
    do_reset();
    clear_mem();
    mem[0] = enc(21, 0, 0, 0, 5); mem[1] = hlt; mem[5] = hlt;
    bus.zero_f = 1'b1;
    f0 = fetch_cnt;
    pulse_start();
    tick(2);
    check("jz_taken_pc_rs", 32'(bus.pc), 32'd0);
    tick(1);
    check("jz_taken_fetch", 32'(bus.imem_rd_en), 32'd1);
    check("jz_taken_addr", 32'(bus.imem_addr), 32'd5);
    wait_halted("jz_taken_halt");
    check("jz_taken_last", 32'(last_fetch), 32'd5);
    check("jz_taken_nfetch", 32'(fetch_cnt - f0), 32'd2);

    do_reset();
    bus.zero_f = 1'b0;
    pulse_start();
    tick(3);
    check("jz_not_addr", 32'(bus.imem_addr), 32'd1);
    wait_halted("jz_not_halt");
    check("jz_not_pc", 32'(bus.pc), 32'd1);

    do_reset();
    mem[0] = enc(18, 0, 0, 0, 5);
    bus.carry_f = 1'b1;
    pulse_start();
    wait_halted("jnc_halt");
    check("jnc_not_pc", 32'(bus.pc), 32'd1);
    bus.carry_f = 1'b0;

    do_reset();
    mem[0] = enc(23, 0, 0, 0, 5);
    bus.ovf_f = 1'b1;
    pulse_start();
    wait_halted("jo_halt");
    check("jo_taken_pc", 32'(bus.pc), 32'd5);
    bus.ovf_f = 1'b0;

    // Wrap: jump to 15 (upper target bits discarded), AND, pc wraps to 0
    do_reset();
    clear_mem();
    mem[0] = enc(16, 0, 0, 0, 16'h00FF); mem[15] = andop;
    bus.ex_ready = 1'b1;
    pulse_start();
    wait_valid("wrap_v");
    check("wrap_ir", bus.ir, andop);
    check("wrap_pc15", 32'(bus.pc), 32'd15);
    tick(1);
    bus.ex_done = 1'b1; tick(1); bus.ex_done = 1'b0;
    check("wrap_pc0", 32'(bus.pc), 32'd0);
    tick(1);
    check("wrap_fetch", 32'(bus.imem_rd_en), 32'd1);
    check("wrap_addr", 32'(bus.imem_addr), 32'd0);

    // Reset mid-issue with stray ex_done afterwards
    do_reset();
    clear_mem();
    mem[0] = adi; mem[1] = hlt;
    bus.ex_ready = 1'b0;
    pulse_start();
    wait_valid("mid_v");
    sys_rst = 1'b1; tick(1); sys_rst = 1'b0;
    bus.ex_done = 1'b1; tick(1); bus.ex_done = 1'b0;
    check("mid_valid", 32'(bus.ir_valid), 32'd0);
    check("mid_pc", 32'(bus.pc), 32'd0);
    check("mid_ir", bus.ir, 32'd0);
    f0 = fetch_cnt;
    tick(10);
    check("mid_nofetch", 32'(fetch_cnt - f0), 32'd0);
    check("mid_pc_idle", 32'(bus.pc), 32'd0);
    check("mid_halted", 32'(bus.halted), 32'd0);
    bus.ex_ready = 1'b1;
    pulse_start();
    wait_valid("mid_restart_v");
    check("mid_restart_ir", bus.ir, adi);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
